lottery_input_cond: RTL and testbench
=====================================

LOTTERY_INPUT_COND -- requirements
Module: lottery_input_cond

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable cycles required to accept a key level change (range 2..2^20).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port key_insert_n  input  1  raw pushbutton, active-low (0 = pressed), asynchronous.
REQ-005 SHALL have port key_finish_n  input  1  raw pushbutton, active-low, asynchronous.
REQ-006 SHALL have port sw_num  input  4  raw digit switches, asynchronous.
REQ-007 SHALL have port insert  output  1  one-cycle pulse to the lottery FSM: accepted digit.
REQ-008 SHALL have port finish  output  1  one-cycle pulse to the lottery FSM: end of entry.
REQ-009 SHALL have port num  output  4  registered digit, valid from the insert cycle, held until next accepted digit.
REQ-010 SHALL have port digit_err  output  1  one-cycle pulse: insert pressed with sw_num > 9.
REQ-011 SHALL have port count  output  3  accepted digits so far, 0..5.

Function
REQ-012 SHALL pass key_insert_n, key_finish_n and sw_num each through a 2-flop synchronizer before any use.
REQ-013 SHALL keep, per key, a debounced stable level and a counter; counter clears whenever synced level equals stable level, else increments; stable level flips when counter reaches DEBOUNCE_CYCLES, counter then clears.
REQ-014 SHALL generate a press event only on stable level 1->0; release (0->1) generates no event.
REQ-015 SHALL ignore bounce: any synced excursion shorter than DEBOUNCE_CYCLES consecutive cycles produces no event.
REQ-016 SHALL produce outputs exactly DEBOUNCE_CYCLES+3 rising edges after the first edge sampling the key low (2 sync, DEBOUNCE_CYCLES count, 1 output register).
REQ-017 SHALL implement states COLLECT (count<5), READY (count==5), DONE.
REQ-018 In COLLECT, insert press with synced sw_num <= 9: num <= sw_num, insert=1 one cycle, count+1; reaching 5 moves to READY.
REQ-019 In COLLECT, insert press with synced sw_num > 9: digit_err=1 one cycle; num, count, state unchanged; no insert.
REQ-020 In COLLECT, finish press SHALL be ignored (no pulse, no state change).
REQ-021 In READY, insert press SHALL be ignored (no insert, no digit_err); finish press: finish=1 one cycle, go to DONE.
REQ-022 In DONE, all presses SHALL be ignored until reset.
REQ-023 Simultaneous insert and finish press events in one cycle: insert evaluated against current state first; finish evaluated against state before that cycle (so in COLLECT finish is dropped, in READY insert is dropped).
REQ-024 insert, finish, digit_err SHALL never be high in two consecutive cycles; at most one of insert/finish high per cycle.
REQ-025 count SHALL never exceed 5; no wrap-around.
REQ-026 A key held continuously SHALL yield exactly one event per press.

Reset
REQ-027 On reset: insert=0, finish=0, digit_err=0, num=0, count=0, state COLLECT, debounce counters 0, synchronizer flops 1.
REQ-028 Debounced stable levels SHALL reset to pressed (0), so a key held through reset produces no event until released for DEBOUNCE_CYCLES cycles and pressed again.
REQ-029 Reset asserted mid-debounce or mid-sequence SHALL discard partial counts and pending events; first output cycle after reset release is all-zero.

Verification
REQ-030 DEBOUNCE_CYCLES=16, release keys 20 cycles, press insert with sw_num=5 held 30 cycles -> insert high exactly one cycle at edge 19 after press sampled, num=5, count=1.
REQ-031 Insert key bounces low 10 cycles, high 3, low 10 -> no insert; then held low 16+ cycles -> exactly one insert.
REQ-032 sw_num=12, press insert -> digit_err one cycle, count stays 0, num unchanged, no insert.
REQ-033 Five inserts 5,0,9,6,7 then press finish -> count=5, num=7, one finish pulse; sixth insert and second finish -> no outputs.
REQ-034 Finish pressed at count=3 -> ignored; both keys pressed same cycle at count=5 -> finish only.
REQ-035 Insert held through reset release -> no insert; release 16 cycles, press again -> one insert.

Source files
------------

// File: rtl/lottery_input_cond.sv
`default_nettype none
// ============================================================================
//  Module      : lottery_input_cond
//  Description : Input conditioning for the lottery entry panel. Synchronizes
//                the raw pushbuttons and digit switches, debounces both keys,
//                turns debounced presses into single-cycle events and runs a
//                small collect/ready/done controller that emits insert,
//                finish and digit_err pulses along with the held digit and
//                the running digit count.
//  Revision    : 1.0 - initial release
// ============================================================================
module lottery_input_cond #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_insert_n,
  input  logic       key_finish_n,
  input  logic [3:0] sw_num,
  output logic       insert,
  output logic       finish,
  output logic [3:0] num,
  output logic       digit_err,
  output logic [2:0] count
);

  // Counter only has to reach DEBOUNCE_CYCLES-1 before the level flips.
  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] READY   = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [2:0] MAX_DIGITS      = 3'd5;
  localparam logic [3:0] MAX_DIGIT_VALUE = 4'd9;

  // Bit 0 carries the insert key, bit 1 the finish key.
  logic [1:0] key_meta;
  logic [1:0] key_sync;
  logic [3:0] sw_meta;
  logic [3:0] sw_sync;
  logic [1:0] press;
  logic [1:0] state;

  // Two-flop synchronizers; idle level is all ones (keys released).
  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta <= '1;
      key_sync <= '1;
      sw_meta  <= '1;
      sw_sync  <= '1;
    end else begin
      key_meta <= {key_finish_n, key_insert_n};
      key_sync <= key_meta;
      sw_meta  <= sw_num;
      sw_sync  <= sw_meta;
    end
  end

  generate
    for (genvar k = 0; k < 2; k++) begin : g_debounce
      logic             stable;
      logic [CNT_W-1:0] cnt;
      logic             evt;

      // Accept a new level only after it persists; flag the 1->0 flip as a press.
      always_ff @(posedge clk) begin
        if (reset) begin
          stable <= 1'b0;
          cnt    <= '0;
          evt    <= 1'b0;
        end else begin
          evt <= 1'b0;
          if (key_sync[k] == stable) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            stable <= key_sync[k];
            cnt    <= '0;
            evt    <= ~key_sync[k];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign press[k] = evt;
    end
  endgenerate

  // Entry controller. Finish is judged on the state held before this cycle,
  // so an insert that completes the fifth digit never coincides with finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= COLLECT;
      insert    <= 1'b0;
      finish    <= 1'b0;
      digit_err <= 1'b0;
      num       <= 4'd0;
      count     <= 3'd0;
    end else begin
      insert    <= 1'b0;
      finish    <= 1'b0;
      digit_err <= 1'b0;
      case (state)
        COLLECT: begin
          if (press[0]) begin
            if (sw_sync <= MAX_DIGIT_VALUE) begin
              num    <= sw_sync;
              insert <= 1'b1;
              count  <= count + 3'd1;
              if (count == MAX_DIGITS - 3'd1) begin
                state <= READY;
              end
            end else begin
              digit_err <= 1'b1;
            end
          end
        end
        READY: begin
          if (press[1]) begin
            finish <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lottery_input_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lottery_input_cond
//  Description : Scoreboard bench for lottery_input_cond. A reference model
//                of the panel behaviour predicts every pulse and the visible
//                digit/count; a negedge monitor compares against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lottery_input_cond;

  localparam int DEB   = 16;
  localparam int MAXC  = 16384;
  localparam int K_INS = 0;
  localparam int K_FIN = 1;
  localparam int K_ERR = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_insert_n = 1'b1;
  logic       key_finish_n = 1'b1;
  logic [3:0] sw_num = 4'd0;
  logic       insert;
  logic       finish;
  logic [3:0] num;
  logic       digit_err;
  logic [2:0] count;

  lottery_input_cond #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_insert_n (key_insert_n),
    .key_finish_n (key_finish_n),
    .sw_num       (sw_num),
    .insert       (insert),
    .finish       (finish),
    .num          (num),
    .digit_err    (digit_err),
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    int         kind;
    logic [3:0] dnum;
    logic [2:0] dcnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   edge_n = 0;
  int   fin_seen = 0;

  // Raw values as captured at each rising edge, and predicted visible state.
  bit       smp_ins [MAXC];
  bit       smp_fin [MAXC];
  bit [3:0] smp_sw  [MAXC];
  bit [3:0] vis_num [MAXC];
  bit [2:0] vis_cnt [MAXC];

  // Reference model state: accepted key level and length of the current
  // disagreeing run, plus the entry progress.
  bit       acc [2];
  int       run [2];
  int       m_cnt;
  bit [3:0] m_num;
  bit       m_done;
  bit [2:0] prev_flags = 3'b000;

  function automatic bit deb(input int k, input bit s);
    deb = 1'b0;
    if (s != acc[k]) begin
      run[k]++;
      if (run[k] == DEB) begin
        acc[k] = s;
        run[k] = 0;
        deb    = (s == 1'b0);
      end
    end else begin
      run[k] = 0;
    end
  endfunction

  task automatic push_exp(input int at, input int kind);
    exp_t e;
    e.at   = at;
    e.kind = kind;
    e.dnum = m_num;
    e.dcnt = 3'(m_cnt);
    q.push_back(e);
  endtask

  // Edge n: a key sample reaches the debouncer two edges after capture, a
  // press is visible one edge after acceptance, using the digit captured one
  // edge earlier than the press becomes visible minus one.
  task automatic model_step(input int n, input bit r);
    bit       ev_i;
    bit       ev_f;
    bit       was_ready;
    bit [3:0] sw;
    if (r) begin
      smp_ins[n] = 1'b1; smp_fin[n] = 1'b1; smp_sw[n] = 4'hF;
      smp_ins[n-1] = 1'b1; smp_fin[n-1] = 1'b1; smp_sw[n-1] = 4'hF;
      acc[0] = 1'b0; acc[1] = 1'b0; run[0] = 0; run[1] = 0;
      m_cnt = 0; m_num = 4'd0; m_done = 1'b0;
      vis_num[n] = 4'd0; vis_cnt[n] = 3'd0;
      vis_num[n+1] = 4'd0; vis_cnt[n+1] = 3'd0;
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].at >= n) q.delete(i);
    end else begin
      ev_i = deb(0, smp_ins[n-2]);
      ev_f = deb(1, smp_fin[n-2]);
      sw   = smp_sw[n-1];
      was_ready = (m_cnt == 5) && !m_done;
      if (ev_i && !m_done && m_cnt < 5) begin
        if (sw <= 4'd9) begin
          m_num = sw;
          m_cnt++;
          push_exp(n + 1, K_INS);
        end else begin
          push_exp(n + 1, K_ERR);
        end
      end
      if (ev_f && was_ready) begin
        m_done = 1'b1;
        push_exp(n + 1, K_FIN);
      end
      vis_num[n+1] = m_num;
      vis_cnt[n+1] = 3'(m_cnt);
    end
  endtask

  task automatic step(input bit r, input bit ki, input bit kf, input logic [3:0] sw);
    reset = r; key_insert_n = ki; key_finish_n = kf; sw_num = sw;
    @(posedge clk);
    edge_n++;
    if (edge_n >= MAXC - 2) begin
      $display("FAIL cycle_budget: reached edge %0d, limit %0d", edge_n, MAXC - 2);
      $fatal(1, "cycle budget exhausted");
    end
    smp_ins[edge_n] = ki;
    smp_fin[edge_n] = kf;
    smp_sw[edge_n]  = sw;
    model_step(edge_n, r);
    #1;
  endtask

  task automatic hold(input int n, input bit ki, input bit kf, input logic [3:0] sw);
    repeat (n) step(1'b0, ki, kf, sw);
  endtask

  task automatic press_ins(input logic [3:0] sw);
    hold(25, 1'b0, 1'b1, sw);
    hold(25, 1'b1, 1'b1, sw);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: visible digit/count every cycle, pulses popped from the scoreboard.
  always @(negedge clk) begin
    if (edge_n > 0) begin
      n_vec++;
      if (num !== vis_num[edge_n] || count !== vis_cnt[edge_n]) begin
        n_bad++;
        $display("FAIL state @%0d: num=%0d count=%0d, expected num=%0d count=%0d",
                 edge_n, num, count, vis_num[edge_n], vis_cnt[edge_n]);
      end
      if (finish === 1'b1) fin_seen++;
      if ((prev_flags & {insert, finish, digit_err}) != 3'b000) begin
        n_bad++;
        $display("FAIL back_to_back @%0d: flags=%b previous=%b", edge_n,
                 {insert, finish, digit_err}, prev_flags);
      end
      prev_flags = {insert === 1'b1, finish === 1'b1, digit_err === 1'b1};
      if (insert !== 1'b0 || finish !== 1'b0 || digit_err !== 1'b0) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse @%0d: ins/fin/err=%b, expected none",
                   edge_n, {insert, finish, digit_err});
        end else begin
          mon_e = q.pop_front();
          if (mon_e.at != edge_n ||
              {insert, finish, digit_err} !== ((mon_e.kind == K_INS) ? 3'b100 :
                                               (mon_e.kind == K_FIN) ? 3'b010 : 3'b001)) begin
            n_bad++;
            $display("FAIL pulse @%0d: ins/fin/err=%b, expected kind %0d at edge %0d",
                     edge_n, {insert, finish, digit_err}, mon_e.kind, mon_e.at);
          end
        end
      end else if (q.size() > 0 && q[0].at < edge_n) begin
        n_vec++;
        n_bad++;
        $display("FAIL missing_pulse @%0d: got none, expected kind %0d at edge %0d",
                 edge_n, q[0].kind, q[0].at);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    repeat (4) step(1'b1, 1'b1, 1'b1, 4'd0);
    chk("reset_insert", int'(insert), 0);
    chk("reset_finish", int'(finish), 0);
    chk("reset_digit_err", int'(digit_err), 0);
    chk("reset_num", int'(num), 0);
    chk("reset_count", int'(count), 0);
    hold(20, 1'b1, 1'b1, 4'd0);

    // Single press of digit 5: pulse lands 18 edges after the first low capture.
    hold(18, 1'b0, 1'b1, 4'd5);
    chk("latency_before", int'(insert), 0);
    step(1'b0, 1'b0, 1'b1, 4'd5);
    chk("latency_insert", int'(insert), 1);
    hold(11, 1'b0, 1'b1, 4'd5);
    chk("first_count", int'(count), 1);
    chk("first_num", int'(num), 5);
    hold(25, 1'b1, 1'b1, 4'd5);

    // Bounce: short low excursions never count, a long hold counts once.
    hold(10, 1'b0, 1'b1, 4'd3);
    hold(3, 1'b1, 1'b1, 4'd3);
    hold(10, 1'b0, 1'b1, 4'd3);
    chk("bounce_no_insert", int'(count), 1);
    hold(30, 1'b0, 1'b1, 4'd3);
    chk("bounce_one_insert", int'(count), 2);
    hold(25, 1'b1, 1'b1, 4'd3);

    // Out-of-range digit.
    press_ins(4'd12);
    chk("bad_digit_count", int'(count), 2);
    chk("bad_digit_num", int'(num), 3);

    // Full entry sequence with ignored finish, joint press and extras.
    repeat (3) step(1'b1, 1'b1, 1'b1, 4'd0);
    hold(20, 1'b1, 1'b1, 4'd0);
    fin_seen = 0;
    press_ins(4'd5); press_ins(4'd0); press_ins(4'd9);
    hold(25, 1'b1, 1'b0, 4'd9);
    hold(25, 1'b1, 1'b1, 4'd9);
    chk("early_finish_count", int'(count), 3);
    chk("early_finish_none", fin_seen, 0);
    press_ins(4'd6); press_ins(4'd7);
    chk("full_count", int'(count), 5);
    chk("full_num", int'(num), 7);
    hold(25, 1'b0, 1'b0, 4'd7);
    hold(25, 1'b1, 1'b1, 4'd7);
    chk("joint_finish", fin_seen, 1);
    press_ins(4'd2);
    hold(25, 1'b1, 1'b0, 4'd2);
    hold(25, 1'b1, 1'b1, 4'd2);
    chk("done_count", int'(count), 5);
    chk("done_num", int'(num), 7);
    chk("done_finish", fin_seen, 1);

    // Key held straight through reset.
    hold(20, 1'b0, 1'b1, 4'd4);
    repeat (3) step(1'b1, 1'b0, 1'b1, 4'd4);
    hold(30, 1'b0, 1'b1, 4'd4);
    chk("held_reset_count", int'(count), 0);
    hold(20, 1'b1, 1'b1, 4'd4);
    hold(25, 1'b0, 1'b1, 4'd4);
    chk("repress_count", int'(count), 1);
    chk("repress_num", int'(num), 4);
    hold(25, 1'b1, 1'b1, 4'd4);

    // Random key levels, digits, durations and occasional short resets.
    for (int s = 0; s < 150; s++) begin
      bit         ki;
      bit         kf;
      logic [3:0] sw;
      ki = 1'($urandom % 2);
      kf = 1'($urandom % 2);
      sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0)
        repeat ($urandom_range(1, 3)) step(1'b1, ki, kf, sw);
      else
        hold($urandom_range(1, 40), ki, kf, sw);
    end

    hold(40, 1'b1, 1'b1, 4'd0);
    while (q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL never_seen: got none, expected kind %0d at edge %0d", q[0].kind, q[0].at);
      void'(q.pop_front());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
